seq_pattern_detector: RTL and testbench
=======================================

// Module: seq_pattern_detector
// PURPOSE
//  Serial bit-stream pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits.
//  Overlapping or non-overlapping matching, selectable at configuration time; saturating match counter.
//  Successor to the fixed 5-bit FSM detector; sits on the serial input path ahead of the frame logic.
// PARAMETERS
//  MAX_LEN      8        maximum pattern length in bits (>=1)
//  CNT_W        16       match_count width
//  DEF_PATTERN  8'h1A    pattern loaded at reset; LSB-aligned, low DEF_LEN bits used
//  DEF_LEN      5        pattern length loaded at reset
// PORTS
//  clk            in   1                   rising-edge clock
//  rst            in   1                   synchronous reset, active-low
//  cfg_load       in   1                   latch cfg_pattern/cfg_len/cfg_overlap this cycle
//  cfg_pattern    in   MAX_LEN             pattern, LSB-aligned; bit [len-1] is received first
//  cfg_len        in   $clog2(MAX_LEN+1)   pattern length
//  cfg_overlap    in   1                   1 = overlapping matches, 0 = non-overlapping
//  in_valid       in   1                   stream_in is valid this cycle
//  stream_in      in   1                   serial data bit
//  count_clr      in   1                   clear match_count
//  pattern_found  out  1                   one-cycle match pulse (registered)
//  match_count    out  CNT_W               number of matches, saturating
// BEHAVIOUR
//  Reset (rst==0 at an edge): hist=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=1,
//    pattern_found=0, match_count=0. Reset wins over all other inputs, including mid-stream.
//  State: hist[MAX_LEN-1:0] shift register; fill counter 0..MAX_LEN (saturates at MAX_LEN).
//  Accepted bit (in_valid=1, cfg_load=0): nhist={hist[MAX_LEN-2:0],stream_in}; nfill=min(fill+1,MAX_LEN).
//  Match: len!=0 && nfill>=len && (nhist & mask)==(pattern & mask); mask = low len bits.
//  Latency: pattern_found is 1 in the cycle immediately after the edge that accepts the
//    completing bit, and is 0 in every other cycle. An idle cycle (in_valid=0) clears it and holds hist/fill.
//  Non-overlap mode: on a match, fill<=0, so the next match needs len fresh bits.
//    Overlap mode: fill<=nfill.
//  cfg_load=1: latch the new configuration, clear hist and fill, pattern_found<=0, and
//    ignore stream_in that cycle. match_count is not affected.
//  cfg_len=0: no matches. cfg_len>MAX_LEN: clamped to MAX_LEN.
//  match_count: +1 per match and holds at 2^CNT_W-1. count_clr<=0 and takes priority over
//    a same-cycle match, which is then not counted. pattern_found still pulses.
//  FSM: IDLE (fill<len) -> ARMED (fill>=len; any accepted bit can match) -> IDLE on cfg_load,
//    on reset, or after a non-overlap match.
// CONFIGURATION
//  PD_MATCH_COUNT_EN defined: match counter and count_clr are implemented as above.
//  PD_MATCH_COUNT_EN undefined: no counter flops; match_count is tied to 0 and count_clr is
//    ignored. pattern_found behaviour is identical in both builds.
// TESTING
//  1. Reset defaults: drive stream 20'b01101011111010011010 (MSB first, in_valid=1) ->
//     pulses after bits 6, 14 and 20; match_count=3.
//  2. cfg_load with pattern=3'b101, len=3, overlap=1; stream 10101 -> pulses after bits 3 and 5; count+=2.
//     Repeat with overlap=0 -> only the pulse after bit 3.
//  3. in_valid gaps: insert 2 idle cycles inside the 11010 sequence -> the pulse is delayed
//     and occurs exactly once. pattern_found=0 during the idle cycles.
//  4. Saturation: CNT_W=4, pattern=1'b1, len=1, 20 ones -> 20 pulses; match_count=15.
//     count_clr on a match cycle -> match_count=0.
//  5. rst=0 after bit 4 of 11010, then resume with the remaining bits -> no pulse,
//     and all outputs hold their reset values.
//  6. cfg_len=0 -> never pulses. cfg_len=MAX_LEN+3 -> behaves as len=MAX_LEN.
//     cfg_load asserted mid-match -> no pulse.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: runtime-programmable 1..MAX_LEN-bit pattern, overlap/non-overlap matching.
// Optional saturating match counter enabled by defining PD_MATCH_COUNT_EN.
module seq_pattern_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'h1A,
    parameter int                 DEF_LEN     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         in_valid,
    input  logic                         stream_in,
    input  logic                         count_clr,
    output logic                         pattern_found,
    output logic [CNT_W-1:0]             match_count
);

    localparam int                LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  DEF_LEN_V = LEN_W'(DEF_LEN);

    typedef enum logic {
        IDLE,
        ARMED
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               found_q, found_d;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] nhist;
    logic [LEN_W-1:0]   nfill;
    logic               accept;
    logic               match;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    // In ARMED the history already holds len bits, so any accepted bit may complete a match.
    always_comb begin
        accept = in_valid && !cfg_load;
        nhist  = MAX_LEN'({hist_q, stream_in});
        nfill  = (fill_q == MAX_LEN_V) ? fill_q : fill_q + LEN_W'(1);
        match  = accept && (len_q != '0)
                 && ((state_q == ARMED) || (nfill >= len_q))
                 && ((nhist & mask) == (pattern_q & mask));
    end

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        found_d   = 1'b0;
        state_d   = state_q;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = (cfg_len > MAX_LEN_V) ? MAX_LEN_V : cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (accept) begin
            hist_d  = nhist;
            fill_d  = (match && !overlap_q) ? '0 : nfill;
            found_d = match;
        end

        case (state_q)
            IDLE:    if ((len_d != '0) && (fill_d >= len_d)) state_d = ARMED;
            ARMED:   if (cfg_load || (fill_d < len_d))       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-low, so it is sampled only at the clock edge; state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN_V;
            overlap_q <= 1'b1;
            found_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            found_q   <= found_d;
        end
    end

    assign pattern_found = found_q;

`ifdef PD_MATCH_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // A clear beats a same-cycle match; the counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (match && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign match_count = count_q;
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: a vector table plus hand-written reset/saturation sequences.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_seq_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
`ifdef PD_MATCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               stream_in;
    logic               count_clr;
    logic               pattern_found;
    logic [15:0]        match_count;
    logic               sat_found;
    logic [3:0]         sat_count;

    int errors  = 0;
    int checks  = 0;
    int exp_cnt = 0;
    int exp_sat = 0;

    typedef struct {
        string              tag;
        logic               ld;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ovl;
        logic               v;
        logic               b;
        logic               clr;
        logic               exp_found;
    } vec_t;

    vec_t vecs[$];

    seq_pattern_detector dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .in_valid     (in_valid),
        .stream_in    (stream_in),
        .count_clr    (count_clr),
        .pattern_found(pattern_found),
        .match_count  (match_count)
    );

    seq_pattern_detector #(.CNT_W(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .in_valid     (in_valid),
        .stream_in    (stream_in),
        .count_clr    (count_clr),
        .pattern_found(sat_found),
        .match_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string tag, input logic v, input logic b,
                                input logic clr, input logic exp_found);
        vec_t r;
        r.tag = tag; r.ld = 1'b0; r.pat = '0; r.len = '0; r.ovl = 1'b0;
        r.v = v; r.b = b; r.clr = clr; r.exp_found = exp_found;
        return r;
    endfunction

    function automatic vec_t mk_load(input string tag, input logic [MAX_LEN-1:0] pat,
                                     input logic [LEN_W-1:0] len, input logic ovl);
        vec_t r;
        r = mk(tag, 1'b1, 1'b1, 1'b0, 1'b0);
        r.ld = 1'b1; r.pat = pat; r.len = len; r.ovl = ovl;
        return r;
    endfunction

    // '-' in bits is an idle cycle; exp holds '1' where a pulse must follow that cycle's edge.
    function automatic void add_stream(input string tag, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            vecs.push_back(mk($sformatf("%s.%0d", tag, i + 1), bits.getc(i) != "-",
                              bits.getc(i) == "1", 1'b0, exp.getc(i) == "1"));
        end
    endfunction

    task automatic step(input vec_t r);
        @(negedge clk);
        rst         = 1'b1;
        cfg_load    = r.ld;
        cfg_pattern = r.pat;
        cfg_len     = r.len;
        cfg_overlap = r.ovl;
        in_valid    = r.v;
        stream_in   = r.b;
        count_clr   = r.clr;
        @(posedge clk);
        #1;
        if (r.clr) begin
            exp_cnt = 0;
            exp_sat = 0;
        end else if (r.exp_found) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_sat < 15)    exp_sat++;
        end
        check({r.tag, " found"},     32'(pattern_found), 32'(r.exp_found));
        check({r.tag, " sat_found"}, 32'(sat_found),     32'(r.exp_found));
        check({r.tag, " count"},     32'(match_count),   CNT_EN ? exp_cnt : 0);
        check({r.tag, " sat_count"}, 32'(sat_count),     CNT_EN ? exp_sat : 0);
    endtask

    task automatic run_stream(input string tag, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            step(mk($sformatf("%s.%0d", tag, i + 1), bits.getc(i) != "-",
                    bits.getc(i) == "1", 1'b0, exp.getc(i) == "1"));
        end
    endtask

    // Reset is held for one edge while a valid bit is offered, to show reset wins.
    task automatic do_reset(input string tag, input logic v, input logic b);
        @(negedge clk);
        rst       = 1'b0;
        cfg_load  = 1'b1;
        in_valid  = v;
        stream_in = b;
        count_clr = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        exp_sat = 0;
        check({tag, " found"},     32'(pattern_found), 0);
        check({tag, " sat_found"}, 32'(sat_found),     0);
        check({tag, " count"},     32'(match_count),   0);
        check({tag, " sat_count"}, 32'(sat_count),     0);
    endtask

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; stream_in = 1'b0; count_clr = 1'b0;

        // Reset defaults: 11010, overlapping.
        add_stream("t1", "01101011111010011010", "00000100000001000001");
        // 101, overlapping then non-overlapping.
        vecs.push_back(mk_load("t2o.load", 8'h05, 4'd3, 1'b1));
        add_stream("t2o", "10101", "00101");
        vecs.push_back(mk_load("t2n.load", 8'h05, 4'd3, 1'b0));
        add_stream("t2n", "10101", "00100");
        // Idle gaps inside 11010, and an idle right after the pulse.
        vecs.push_back(mk_load("t3.load", 8'h1A, 4'd5, 1'b1));
        add_stream("t3", "110--10-", "00000010");
        // Zero length never matches, even with an all-zero pattern.
        vecs.push_back(mk_load("t6a.load", 8'h00, 4'd0, 1'b1));
        add_stream("t6a", "0101100111", "0000000000");
        // Over-long length clamps to MAX_LEN.
        vecs.push_back(mk_load("t6b.load", 8'hA5, 4'd11, 1'b1));
        add_stream("t6b", "1010010100", "0000000100");
        // Reload mid-match discards the partial history.
        vecs.push_back(mk_load("t6c.load", 8'h1A, 4'd5, 1'b1));
        add_stream("t6c", "1101", "0000");
        vecs.push_back(mk_load("t6c.reload", 8'h1A, 4'd5, 1'b1));
        add_stream("t6c.post", "011010", "000001");

        do_reset("reset", 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // Saturation of the narrow counter, then clear on a matching cycle.
        step(mk_load("t4.load", 8'h01, 4'd1, 1'b1));
        run_stream("t4", "11111111111111111111", "11111111111111111111");
        check("t4 saturated", 32'(sat_count), CNT_EN ? 15 : 0);
        step(mk("t4.clr", 1'b1, 1'b1, 1'b1, 1'b1));
        step(mk("t4.after_clr", 1'b1, 1'b1, 1'b0, 1'b1));

        // Mid-stream reset restores the default pattern and drops the partial match.
        step(mk_load("t5.load", 8'h05, 4'd3, 1'b1));
        run_stream("t5.pre", "1101", "0001");
        do_reset("t5.reset", 1'b1, 1'b0);
        run_stream("t5.resume", "0", "0");
        run_stream("t5.default", "11010", "00001");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
